// File: rtl/cam_stream_tx.sv
// OV7670-style parallel camera transmitter: pclk/vsync/href/data carrying
// RGB565 pixels (high byte first) from an internal pattern generator.
// Stands in for the camera so the capture chain can run on known images.
// rst_in asserts asynchronously; its release is expected to be synchronous
// to clk_in.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no frame; outputs low, waits for enable_in at a tick boundary
// S_VSYNC  | vsync_out high for VSYNC_LINES line-times
// S_VBACK  | back porch, V_BACK line-times, vsync/href low
// S_ACTIVE | href_out high, 2*H_ACTIVE byte ticks of line y
// S_HBLANK | H_BLANK ticks of href low after each active line
// S_VFRONT | front porch, V_FRONT line-times, frame_done_out at its end
module cam_stream_tx #(
   parameter int H_ACTIVE    = 320,
   parameter int V_ACTIVE    = 240,
   parameter int H_BLANK     = 32,
   parameter int VSYNC_LINES = 3,
   parameter int V_BACK      = 17,
   parameter int V_FRONT     = 10,
   parameter int CLK_DIV     = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        enable_in,
   input  logic [1:0]  pattern_sel_in,
   input  logic [15:0] color_in,
   output logic        pclk_out,
   output logic        vsync_out,
   output logic        href_out,
   output logic [7:0]  data_out,
   output logic        frame_done_out,
   output logic        busy_out,
   output logic [15:0] frame_count_out
);

   localparam int LINE_TICKS = 2 * H_ACTIVE + H_BLANK;
   localparam logic [31:0] VSYNC_LEN  = 32'(VSYNC_LINES * LINE_TICKS);
   localparam logic [31:0] VBACK_LEN  = 32'(V_BACK * LINE_TICKS);
   localparam logic [31:0] VFRONT_LEN = 32'(V_FRONT * LINE_TICKS);
   localparam logic [31:0] ACTIVE_LEN = 32'(2 * H_ACTIVE);
   localparam logic [31:0] HBLANK_LEN = 32'(H_BLANK);
   localparam int YW = (V_ACTIVE > 256) ? $clog2(V_ACTIVE) : 8;
   localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_HBLANK, S_VFRONT
   } state_t;

   // Phases with a zero line count are never entered.
   localparam state_t FRAME_FIRST = (VSYNC_LINES > 0) ? S_VSYNC :
                                    (V_BACK > 0)      ? S_VBACK : S_ACTIVE;
   localparam state_t AFTER_VSYNC = (V_BACK > 0) ? S_VBACK : S_ACTIVE;

   logic [15:0]   div_cnt;
   logic          tick;

   state_t        state, state_nxt;
   logic [31:0]   cnt, cnt_nxt;
   // Only x[7:0] feeds the patterns; bar position is tracked separately,
   // so an 8-bit wrapping x is sufficient for any line width.
   logic [7:0]    x, x_nxt;
   logic          lo, lo_nxt;
   logic [YW-1:0] y, y_nxt;
   logic [2:0]    bar, bar_nxt;
   logic [15:0]   acc, acc_nxt, acc_sum;
   logic [1:0]    pat, pat_nxt;
   logic [15:0]   col, col_nxt;
   logic          frame_end, begin_frame, enter;
   logic [15:0]   pix;

   function automatic logic [31:0] phase_len(input state_t s);
      case (s)
         S_VSYNC:  return VSYNC_LEN - 32'd1;
         S_VBACK:  return VBACK_LEN - 32'd1;
         S_ACTIVE: return ACTIVE_LEN - 32'd1;
         S_HBLANK: return HBLANK_LEN - 32'd1;
         S_VFRONT: return VFRONT_LEN - 32'd1;
         default:  return 32'd0;
      endcase
   endfunction

   // A tick boundary is the clk_in edge on which pclk_out falls.
   assign tick = pclk_out && (div_cnt == '0);

   // Free-running pclk divider: CLK_DIV clk_in cycles per half period.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         div_cnt  <= 16'(CLK_DIV - 1);
         pclk_out <= 1'b0;
      end else if (div_cnt == '0) begin
         div_cnt  <= 16'(CLK_DIV - 1);
         pclk_out <= ~pclk_out;
      end else begin
         div_cnt <= div_cnt - 16'd1;
      end
   end

   // Next state, phase timer and pixel position, evaluated at tick boundaries.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      x_nxt       = x;
      lo_nxt      = lo;
      y_nxt       = y;
      bar_nxt     = bar;
      acc_nxt     = acc;
      pat_nxt     = pat;
      col_nxt     = col;
      frame_end   = 1'b0;
      begin_frame = 1'b0;
      enter       = 1'b0;
      acc_sum     = acc + 16'd8;
      if (tick) begin
         case (state)
            S_IDLE: begin
               if (enable_in) begin_frame = 1'b1;
            end
            S_VSYNC: begin
               if (cnt == '0) begin
                  state_nxt = AFTER_VSYNC;
                  enter     = 1'b1;
               end else cnt_nxt = cnt - 32'd1;
            end
            S_VBACK: begin
               if (cnt == '0) begin
                  state_nxt = S_ACTIVE;
                  enter     = 1'b1;
               end else cnt_nxt = cnt - 32'd1;
            end
            S_ACTIVE: begin
               if (cnt == '0) begin
                  if (H_BLANK > 0) begin
                     state_nxt = S_HBLANK;
                     enter     = 1'b1;
                  end else if (y == Y_LAST) begin
                     if (V_FRONT > 0) begin
                        state_nxt = S_VFRONT;
                        enter     = 1'b1;
                     end else frame_end = 1'b1;
                  end else begin
                     y_nxt = y + 1'b1;
                     enter = 1'b1;
                  end
               end else begin
                  cnt_nxt = cnt - 32'd1;
                  if (lo) begin
                     x_nxt  = x + 8'd1;
                     lo_nxt = 1'b0;
                     // bar = (x*8)/H_ACTIVE kept as quotient/remainder pair;
                     // assumes H_ACTIVE >= 8 so at most one step per pixel.
                     if (acc_sum >= 16'(H_ACTIVE)) begin
                        acc_nxt = acc_sum - 16'(H_ACTIVE);
                        bar_nxt = bar + 3'd1;
                     end else acc_nxt = acc_sum;
                  end else lo_nxt = 1'b1;
               end
            end
            S_HBLANK: begin
               if (cnt == '0) begin
                  if (y == Y_LAST) begin
                     if (V_FRONT > 0) begin
                        state_nxt = S_VFRONT;
                        enter     = 1'b1;
                     end else frame_end = 1'b1;
                  end else begin
                     y_nxt     = y + 1'b1;
                     state_nxt = S_ACTIVE;
                     enter     = 1'b1;
                  end
               end else cnt_nxt = cnt - 32'd1;
            end
            S_VFRONT: begin
               if (cnt == '0) frame_end = 1'b1;
               else cnt_nxt = cnt - 32'd1;
            end
            default: state_nxt = S_IDLE;
         endcase
         if (frame_end) begin
            if (enable_in) begin_frame = 1'b1;
            else begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end
         end
         if (begin_frame) begin
            pat_nxt   = pattern_sel_in;
            col_nxt   = color_in;
            y_nxt     = '0;
            state_nxt = FRAME_FIRST;
            enter     = 1'b1;
         end
         if (enter) begin
            cnt_nxt = phase_len(state_nxt);
            x_nxt   = '0;
            lo_nxt  = 1'b0;
            bar_nxt = '0;
            acc_nxt = '0;
         end
      end
   end

   // State register and frame/line position counters.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state <= S_IDLE;
         cnt   <= '0;
         x     <= '0;
         lo    <= 1'b0;
         y     <= '0;
         bar   <= '0;
         acc   <= '0;
         pat   <= '0;
         col   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         x     <= x_nxt;
         lo    <= lo_nxt;
         y     <= y_nxt;
         bar   <= bar_nxt;
         acc   <= acc_nxt;
         pat   <= pat_nxt;
         col   <= col_nxt;
      end
   end

   // Pixel of the tick about to start, so no pipeline latency is exposed.
   always_comb begin
      pix = 16'h0000;
      case (pat_nxt)
         2'd0: pix = col_nxt;
         2'd1: begin
            case (bar_nxt)
               3'd0: pix = 16'hFFFF;
               3'd1: pix = 16'hFFE0;
               3'd2: pix = 16'h07FF;
               3'd3: pix = 16'h07E0;
               3'd4: pix = 16'hF81F;
               3'd5: pix = 16'hF800;
               3'd6: pix = 16'h001F;
               default: pix = 16'h0000;
            endcase
         end
         2'd2: pix = {x_nxt[7:3], y_nxt[7:2], x_nxt[4:0]};
         default: pix = (x_nxt[4] ^ y_nxt[4]) ? 16'hFFFF : 16'h0000;
      endcase
   end

   // Stream outputs change only at tick boundaries; frame bookkeeping.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         vsync_out       <= 1'b0;
         href_out        <= 1'b0;
         data_out        <= 8'h00;
         frame_done_out  <= 1'b0;
         frame_count_out <= 16'h0000;
      end else begin
         frame_done_out <= frame_end;
         if (frame_end) frame_count_out <= frame_count_out + 16'd1;
         if (tick) begin
            vsync_out <= (state_nxt == S_VSYNC);
            href_out  <= (state_nxt == S_ACTIVE);
            if (state_nxt == S_ACTIVE) data_out <= lo_nxt ? pix[7:0] : pix[15:8];
            else data_out <= 8'h00;
         end
      end
   end

   assign busy_out = (state != S_IDLE);

endmodule

// File: tb/tb_cam_stream_tx.sv
// Bench for cam_stream_tx: receiver model reassembling pixels at pclk rising
// edges, timing checks on vsync/href/frame_done, and a table of known pixels.
module tb_cam_stream_tx;

   localparam int H  = 32;
   localparam int V  = 18;
   localparam int HB = 2;
   localparam int VSL = 1;
   localparam int VB = 1;
   localparam int VF = 1;
   localparam int CD = 2;
   localparam int LT = 2 * H + HB;
   localparam int FRAME_TICKS = (VSL + VB + V + VF) * LT;
   localparam int FRAME_CLKS  = FRAME_TICKS * 2 * CD;
   localparam int NFRAMES = 6;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        enable_in;
   logic [1:0]  pattern_sel_in;
   logic [15:0] color_in;
   logic        pclk_out, vsync_out, href_out, frame_done_out, busy_out;
   logic [7:0]  data_out;
   logic [15:0] frame_count_out;

   cam_stream_tx #(
      .H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .VSYNC_LINES(VSL),
      .V_BACK(VB), .V_FRONT(VF), .CLK_DIV(CD)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
      .pattern_sel_in(pattern_sel_in), .color_in(color_in),
      .pclk_out(pclk_out), .vsync_out(vsync_out), .href_out(href_out),
      .data_out(data_out), .frame_done_out(frame_done_out),
      .busy_out(busy_out), .frame_count_out(frame_count_out)
   );

   always #5 clk_in = ~clk_in;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Pixel rules written directly as arithmetic on x, y.
   function automatic int ref_pix(input int pat, input int col, input int x, input int y);
      int b;
      case (pat)
         0: return col & 'hFFFF;
         1: begin
            b = (x * 8) / H;
            case (b)
               0: return 'hFFFF;
               1: return 'hFFE0;
               2: return 'h07FF;
               3: return 'h07E0;
               4: return 'hF81F;
               5: return 'hF800;
               6: return 'h001F;
               default: return 'h0000;
            endcase
         end
         2: return (((x >> 3) & 31) << 11) | (((y >> 2) & 63) << 5) | (x & 31);
         default: return ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 'hFFFF : 'h0000;
      endcase
   endfunction

   typedef struct { int pat; int col; int x; int y; int exp; } vec_t;
   typedef struct { int pat; int col; } fcfg_t;

   vec_t  vecs[$];
   fcfg_t cfg_q[$];
   logic [15:0] cap [V][H];

   bit   mon_en = 1'b0;
   int   frames_started = 0;
   int   cur_pat = 0, cur_col = 0;
   int   line_y = 0, px_x = 0, frame_px = 0;
   int   hr_ticks = 0, gap_ticks = 0, vs_ticks = 0;
   bit   blank_dirty = 1'b0;
   logic [7:0] hi_byte = 8'h00;
   logic prev_vs = 1'b0, prev_hr = 1'b0;

   // Receiver model: samples the stream just after each pclk rising edge.
   always @(posedge pclk_out) begin
      fcfg_t f;
      int    e;
      logic [15:0] p;
      #1;
      if (mon_en) begin
         if (vsync_out && !prev_vs) begin
            vs_ticks = 0; line_y = 0; px_x = 0; frame_px = 0; blank_dirty = 1'b0;
            if (cfg_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL frame_cfg: frame %0d started, none expected", frames_started);
            end else begin
               f = cfg_q.pop_front();
               cur_pat = f.pat; cur_col = f.col;
            end
            frames_started++;
         end
         if (vsync_out) vs_ticks++;
         if (!vsync_out && prev_vs) check("vsync_ticks", vs_ticks, VSL * LT);
         if (href_out) begin
            if (!prev_hr) begin
               if (line_y > 0) check("hblank_ticks", gap_ticks, HB);
               hr_ticks = 0; px_x = 0;
            end
            hr_ticks++;
            if (hr_ticks % 2 == 1) hi_byte = data_out;
            else begin
               p = {hi_byte, data_out};
               e = ref_pix(cur_pat, cur_col, px_x, line_y);
               if (line_y < V && px_x < H) cap[line_y][px_x] = p;
               n_cmp++;
               if (int'(p) != e) begin
                  n_bad++;
                  $display("FAIL pixel (%0d,%0d) pat %0d: got %04h expected %04h",
                           px_x, line_y, cur_pat, p, e);
               end
               px_x++; frame_px++;
            end
         end else begin
            if (prev_hr) begin
               check("href_ticks", hr_ticks, 2 * H);
               line_y++; gap_ticks = 0;
            end
            gap_ticks++;
            if (data_out != 8'h00) blank_dirty = 1'b1;
         end
         prev_vs = vsync_out;
         prev_hr = href_out;
      end
   end

   int     done_cnt = 0;
   longint cyc = 0, last_done = -1;
   logic   prev_done = 1'b0;

   // Frame-end checks on each frame_done_out pulse, sampled on falling clk_in.
   always @(negedge clk_in) begin
      if (mon_en) begin
         cyc++;
         if (prev_done) check("done_width", frame_done_out, 0);
         if (frame_done_out) begin
            done_cnt++;
            check("frame_count", frame_count_out, frames_started);
            check("frame_pixels", frame_px, H * V);
            check("frame_lines", line_y, V);
            check("blank_data_zero", blank_dirty, 0);
            if (last_done >= 0) check("frame_period", cyc - last_done, FRAME_CLKS);
            last_done = cyc;
            for (int i = 0; i < vecs.size(); i++) begin
               if (vecs[i].pat == cur_pat && (cur_pat != 0 || vecs[i].col == cur_col)) begin
                  n_cmp++;
                  if (int'(cap[vecs[i].y][vecs[i].x]) != vecs[i].exp) begin
                     n_bad++;
                     $display("FAIL vec%0d (%0d,%0d) pat %0d: got %04h expected %04h", i,
                              vecs[i].x, vecs[i].y, cur_pat, cap[vecs[i].y][vecs[i].x], vecs[i].exp);
                  end
               end
            end
         end
         prev_done = frame_done_out;
      end
   end

   initial begin
      int    per, last, rises;
      logic  prev_p;
      fcfg_t nc;

      // Known pixels (H=32, V=18): solid, bars x*8/32, gradient, checker.
      vecs.push_back('{0, 'hF81F, 0, 0, 'hF81F});
      vecs.push_back('{0, 'hF81F, 31, 17, 'hF81F});
      vecs.push_back('{1, 0, 0, 0, 'hFFFF});
      vecs.push_back('{1, 0, 3, 5, 'hFFFF});
      vecs.push_back('{1, 0, 4, 0, 'hFFE0});
      vecs.push_back('{1, 0, 8, 0, 'h07FF});
      vecs.push_back('{1, 0, 20, 3, 'hF800});
      vecs.push_back('{1, 0, 28, 0, 'h0000});
      vecs.push_back('{1, 0, 31, 17, 'h0000});
      vecs.push_back('{2, 0, 0, 0, 'h0000});
      vecs.push_back('{2, 0, 9, 4, 'h0829});
      vecs.push_back('{2, 0, 31, 17, 'h189F});
      vecs.push_back('{3, 0, 16, 0, 'hFFFF});
      vecs.push_back('{3, 0, 16, 16, 'h0000});
      vecs.push_back('{3, 0, 0, 0, 'h0000});
      vecs.push_back('{3, 0, 0, 16, 'hFFFF});

      rst_in = 1'b1; enable_in = 1'b0; pattern_sel_in = 2'd0; color_in = 16'h0000;
      repeat (3) @(negedge clk_in);
      check("rst_pclk", pclk_out, 0);
      check("rst_vsync", vsync_out, 0);
      check("rst_href", href_out, 0);
      check("rst_data", data_out, 0);
      check("rst_done", frame_done_out, 0);
      check("rst_busy", busy_out, 0);
      check("rst_count", frame_count_out, 0);
      rst_in = 1'b0;

      // Reset in the middle of an active line.
      pattern_sel_in = 2'd3; enable_in = 1'b1;
      for (int i = 0; i < 2000 && !href_out; i++) @(negedge clk_in);
      check("reach_active", href_out, 1);
      repeat (7) @(negedge clk_in);
      rst_in = 1'b1;
      #1;
      check("midrst_pclk", pclk_out, 0);
      check("midrst_href", href_out, 0);
      check("midrst_data", data_out, 0);
      check("midrst_busy", busy_out, 0);
      enable_in = 1'b0;
      repeat (2) @(negedge clk_in);
      rst_in = 1'b0;
      per = 0; last = -1; rises = 0; prev_p = pclk_out;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_in);
         if (pclk_out && !prev_p) begin
            if (last >= 0) per = i - last;
            last = i;
            rises++;
         end
         prev_p = pclk_out;
      end
      check("pclk_period", per, 2 * CD);
      check("pclk_rises", rises, 40 / (2 * CD));
      check("idle_busy", busy_out, 0);
      check("idle_vsync", vsync_out, 0);

      // Continuous frames; next frame's inputs change while the current one runs.
      mon_en = 1'b1;
      pattern_sel_in = 2'd0; color_in = 16'hF81F;
      cfg_q.push_back('{0, 'hF81F});
      enable_in = 1'b1;
      for (int k = 0; k < NFRAMES; k++) begin
         for (int i = 0; i < 2 * FRAME_CLKS && frames_started <= k; i++) @(negedge clk_in);
         check("frame_started", frames_started, k + 1);
         repeat (600) @(negedge clk_in);
         check("busy_mid_frame", busy_out, 1);
         check("href_mid_frame", href_out, 1);
         case (k)
            0: nc = '{0, 'h07E0};
            1: nc = '{1, int'($urandom & 'hFFFF)};
            2: nc = '{2, int'($urandom & 'hFFFF)};
            3: nc = '{3, int'($urandom & 'hFFFF)};
            default: nc = '{int'($urandom_range(0, 3)), int'($urandom & 'hFFFF)};
         endcase
         pattern_sel_in = 2'(nc.pat);
         color_in = 16'(nc.col);
         if (k < NFRAMES - 1) cfg_q.push_back(nc);
         else enable_in = 1'b0;
      end
      for (int i = 0; i < 2 * FRAME_CLKS && done_cnt < NFRAMES; i++) @(negedge clk_in);
      check("frames_done", done_cnt, NFRAMES);
      repeat (3) @(negedge clk_in);
      check("end_busy", busy_out, 0);
      check("end_count", frame_count_out, NFRAMES);
      repeat (FRAME_CLKS + 100) @(negedge clk_in);
      check("idle_done_cnt", done_cnt, NFRAMES);
      check("idle_frames", frames_started, NFRAMES);
      check("idle_vsync_end", vsync_out, 0);
      check("idle_busy_end", busy_out, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cam_stream_tx.md
Name: cam_stream_tx

Overview:
- Generates an OV7670-style parallel pixel stream: pixel clock, vsync, href and 8-bit data carrying RGB565 pixels, high byte first.
- It is the transmitting end of the interface the camera receive path consumes on ja/jb.
- Used as a camera stand-in for simulation and for board loopback, so the capture, rotate and frame-buffer chain can run on known images.
- Pixel content comes from an internal pattern generator.

Parameters:
- H_ACTIVE, 320: pixels per line.
- V_ACTIVE, 240: active lines per frame.
- H_BLANK, 32: ticks with href low after each active line.
- VSYNC_LINES, 3: line-times with vsync high.
- V_BACK, 17: line-times after vsync before the first active line.
- V_FRONT, 10: line-times after the last active line.
- CLK_DIV, 2: clk_in cycles per pclk half-period (must be ≥1).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-high reset.
- enable_in  input  1  allows frames to start; level sensitive.
- pattern_sel_in  input  2  0 solid, 1 colour bars, 2 gradient, 3 checkerboard.
- color_in  input  16  RGB565 colour for solid pattern.
- pclk_out  output  1  generated pixel clock.
- vsync_out  output  1  frame sync, active high.
- href_out  output  1  line valid, active high.
- data_out  output  8  pixel byte.
- frame_done_out  output  1  one clk_in pulse at end of each frame.
- busy_out  output  1  high while a frame is in progress.
- frame_count_out  output  16  completed frames; wraps.

Behaviour:
- Reset (async assert, released synchronously to clk_in): all outputs 0; state IDLE; all counters 0.
- Tick = one pclk period = 2*CLK_DIV clk_in cycles.
- pclk_out falls at the start of each tick and rises CLK_DIV cycles later.
- vsync_out, href_out and data_out change only on the clk_in edge where pclk_out falls, so they are stable at every pclk_out rising edge.
- pclk_out toggles continuously out of reset, including in IDLE.
- LINE_TICKS = 2*H_ACTIVE + H_BLANK.
- FSM states:
  - IDLE: outputs low. At a tick boundary with enable_in=1, sample pattern_sel_in and color_in into registers and go to VSYNC. Both are held for the whole frame.
  - VSYNC: vsync_out=1 for VSYNC_LINES*LINE_TICKS ticks, then go to VBACK.
  - VBACK: V_BACK*LINE_TICKS ticks with vsync and href low, then go to ACTIVE.
  - ACTIVE: href_out=1 for 2*H_ACTIVE ticks. Even tick 2x carries pixel x high byte [15:8]; odd tick 2x+1 carries [7:0]. Then go to HBLANK.
  - HBLANK: H_BLANK ticks with href=0 and data_out=0. Then go to ACTIVE with y+1, or to VFRONT after line V_ACTIVE-1. With H_BLANK=0, href stays high across lines.
  - VFRONT: V_FRONT*LINE_TICKS ticks, then frame_done_out pulses for 1 clk_in cycle. At the same edge frame_count_out increments (wrapping 0xFFFF→0) and the FSM goes to VSYNC if enable_in=1, else IDLE. Any phase with a zero-line count is skipped.
- busy_out = 1 in every state except IDLE.
- Deasserting enable_in mid-frame does not truncate the frame; the current frame completes.
- Pixel function (x 0..H_ACTIVE-1, y 0..V_ACTIVE-1):
  - 0 solid: color_in as sampled at frame start.
  - 1 colour bars: bar = (x*8)/H_ACTIVE, computed with an incrementing counter, not a divider. Bar colours 0..7 are FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 2 gradient: {x[7:3], y[7:2], x[4:0]}.
  - 3 checkerboard: (x[4]^y[4]) ? FFFF : 0000.
- Pixel generation may be pipelined, but its latency must be hidden so the byte for tick n appears exactly at tick n.
- Frame period = (VSYNC_LINES+V_BACK+V_ACTIVE+V_FRONT)*LINE_TICKS ticks, exact, with no gaps between consecutive frames.

Test Plan:
- Reset mid-ACTIVE with CLK_DIV=2 -> outputs 0 within the reset cycle; after release the FSM stays IDLE and pclk_out has period 4 clk_in cycles.
- Parameters H_ACTIVE=8, V_ACTIVE=4, H_BLANK=2, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, CLK_DIV=1, enable_in=1 ->
  - vsync high for 18 ticks;
  - 4 href bursts of 16 ticks each, separated by 2 low ticks;
  - frame_done_out pulses every 126 ticks;
  - frame_count_out = 3 after 3 frames.
- Solid pattern, color_in=0xF81F -> every href byte pair samples as F8,1F at pclk_out rising edges. Changing color_in mid-frame has no effect until the next frame.
- Colour bars, H_ACTIVE=16 -> x=0,1 give FFFF; x=2 gives FFE0; x=14,15 give 0000. A receiver model reassembles exactly 16*V_ACTIVE pixels.
- Checkerboard, H_ACTIVE=64 -> pixel (16,0)=FFFF, (16,16)=0000, (0,0)=0000.
- enable_in dropped during ACTIVE of the first frame -> that frame completes, frame_done_out pulses once, busy_out falls and the FSM stays IDLE.
